// File: rtl/period_meter.sv
// period_meter: measures qzt_clk cycles between accepted rising edges of clk_in,
// with refractory rejection, lost-signal timeout and a 4-sample running average.
module period_meter #(
    parameter int WIDTH      = 30,
    parameter int MIN_PERIOD = 50000000,
    parameter int MAX_PERIOD = 150000000
) (
    input  logic             qzt_clk,
    input  logic             reset,
    input  logic             clk_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic [WIDTH-1:0] avg_period,
    output logic             avg_valid,
    output logic             rejected,
    output logic             timeout,
    output logic             active
);
    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] MAX_P = WIDTH'(MAX_PERIOD);

    state_t           state;
    logic             s1, s2, s_old;
    logic             rise;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] hist [4];
    logic [WIDTH+1:0] sum;
    logic [2:0]       count4;

    assign rise = s2 & ~s_old;

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state        <= IDLE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s_old        <= 1'b0;
            counter      <= '0;
            sum          <= '0;
            count4       <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            avg_period   <= '0;
            avg_valid    <= 1'b0;
            rejected     <= 1'b0;
            timeout      <= 1'b0;
            active       <= 1'b0;
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else begin
            s1           <= clk_in;
            s2           <= s1;
            s_old        <= s2;
            period_valid <= 1'b0;
            rejected     <= 1'b0;
            timeout      <= 1'b0;
            avg_period   <= sum[WIDTH+1:2];
            case (state)
                IDLE: if (rise) begin
                    state     <= MEASURE;
                    active    <= 1'b1;
                    counter   <= WIDTH'(1);
                    sum       <= '0;
                    count4    <= '0;
                    avg_valid <= 1'b0;
                    for (int i = 0; i < 4; i++) hist[i] <= '0;
                end
                MEASURE: if (rise && counter >= MIN_P) begin
                    period       <= counter;
                    period_valid <= 1'b1;
                    counter      <= WIDTH'(1);
                    hist[0]      <= counter;
                    hist[1]      <= hist[0];
                    hist[2]      <= hist[1];
                    hist[3]      <= hist[2];
                    // the sum never goes negative: the dropped sample is already inside it
                    sum          <= sum + (WIDTH+2)'(counter) - (WIDTH+2)'(hist[3]);
                    count4       <= (count4 == 3'd4) ? 3'd4 : count4 + 3'd1;
                    avg_valid    <= count4 >= 3'd3;
                end else if (rise) begin
                    rejected <= 1'b1;
                    counter  <= counter + WIDTH'(1);
                end else if (counter == MAX_P) begin
                    timeout   <= 1'b1;
                    state     <= IDLE;
                    active    <= 1'b0;
                    avg_valid <= 1'b0;
                    counter   <= '0;
                end else begin
                    counter <= counter + WIDTH'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: random and directed edge trains checked through a scoreboard
// fed by an edge-time reference model.
module tb_period_meter;
    localparam int W    = 30;
    localparam int MINP = 4;
    localparam int MAXP = 100;

    logic         qzt_clk = 1'b0;
    logic         reset   = 1'b1;
    logic         clk_in  = 1'b0;
    logic [W-1:0] period, avg_period;
    logic         period_valid, avg_valid, rejected, timeout, active;

    period_meter #(.WIDTH(W), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)) dut (
        .qzt_clk(qzt_clk), .reset(reset), .clk_in(clk_in),
        .period(period), .period_valid(period_valid),
        .avg_period(avg_period), .avg_valid(avg_valid),
        .rejected(rejected), .timeout(timeout), .active(active)
    );

    always #5 qzt_clk = ~qzt_clk;

    typedef struct {int kind; int per; int avg; bit avgv;} exp_t;
    exp_t sb[$];
    int   checks = 0, errors = 0;

    // model state, expressed in clk_in rise times (constant sync latency cancels)
    int   now = 0, last_t = 0, last_per = 0, naccept = 0;
    bit   armed = 0;
    int   hist[$];

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge(int t);
        int d, s;
        if (!armed) begin
            armed = 1; last_t = t; naccept = 0; hist.delete();
        end else begin
            d = t - last_t;
            if (d >= MINP) begin
                hist.push_back(d);
                if (hist.size() > 4) void'(hist.pop_front());
                s = 0;
                foreach (hist[i]) s += hist[i];
                naccept++; last_per = d; last_t = t;
                sb.push_back('{0, d, s / 4, naccept >= 4});
            end else begin
                sb.push_back('{1, 0, 0, 0});
            end
        end
    endfunction

    task automatic step();
        @(negedge qzt_clk);
        now++;
        clk_in = 1'b0;
        if (armed && now - last_t == MAXP) begin
            armed = 0;
            sb.push_back('{2, last_per, 0, 0});
        end
    endtask

    task automatic rise();
        @(negedge qzt_clk);
        now++;
        clk_in = 1'b1;
        model_edge(now);
    endtask

    task automatic gap(int n);
        repeat (n - 1) step();
        rise();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_period_valid"}, period_valid, 0);
        chk({tag, "_avg_period"}, avg_period, 0);
        chk({tag, "_avg_valid"}, avg_valid, 0);
        chk({tag, "_rejected"}, rejected, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_active"}, active, 0);
    endtask

    // monitor
    bit pend = 0;
    int pend_avg = 0;
    always @(negedge qzt_clk) begin
        exp_t e;
        int   act_kind;
        if (!reset) begin
            if (pend) begin
                chk("avg_period", avg_period, pend_avg);
                pend = 0;
            end
            if (period_valid || rejected || timeout) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: pv=%0b rej=%0b to=%0b, expected no event (t=%0t)",
                             period_valid, rejected, timeout, $time);
                end else begin
                    e = sb.pop_front();
                    act_kind = period_valid ? 0 : rejected ? 1 : 2;
                    chk("event_kind", act_kind, e.kind);
                    chk("pulse_count", int'(period_valid) + int'(rejected) + int'(timeout), 1);
                    if (e.kind == 0) begin
                        chk("period", period, e.per);
                        chk("avg_valid", avg_valid, e.avgv);
                        pend = 1;
                        pend_avg = e.avg;
                    end else if (e.kind == 2) begin
                        chk("timeout_period_held", period, e.per);
                        chk("timeout_active", active, 0);
                        chk("timeout_avg_valid", avg_valid, 0);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge qzt_clk);
        chk_zero("reset");
        reset = 1'b0;
        // steady 20-cycle train
        gap(5);
        repeat (4) step();
        chk("armed_active", active, 1);
        gap(16);
        repeat (4) gap(20);
        // ramping periods
        gap(20); gap(24); gap(28); gap(32);
        // refractory rejection keeps counting
        gap(2); gap(18);
        // lost signal, re-arm, then measure
        repeat (110) step();
        gap(40); gap(30);
        // boundaries
        gap(100); gap(4);
        // reset in mid-interval
        gap(10);
        repeat (9) step();
        @(negedge qzt_clk);
        now++;
        reset = 1'b1;
        armed = 0;
        @(negedge qzt_clk);
        now++;
        chk_zero("midreset");
        reset = 1'b0;
        gap(5); gap(15);
        // random trains, including rejections and timeouts
        repeat (60) gap($urandom_range(2, 115));
        repeat (116) step();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the interval between rising edges of a slow input, for example the R-peak pulse train from the ECG detection chain. Result is a count of qzt_clk cycles.
- Inverse of the frequency divider: the divider turns a period into a clock; this block turns a clock back into a period.
- Output feeds heart-rate computation and display logic. Includes a refractory window against double triggers, a timeout for lost signal, and a 4-sample running average.

Parameters:
- WIDTH, 30, width of the period counter and all period outputs.
- MIN_PERIOD, 50000000, refractory window in qzt_clk cycles. Edges arriving sooner after the last accepted edge are rejected.
- MAX_PERIOD, 150000000, timeout in qzt_clk cycles. Must be < 2^WIDTH and > MIN_PERIOD.

Ports:
- qzt_clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_in  in  1  asynchronous pulse input to be measured.
- period  out  WIDTH  last accepted interval in qzt_clk cycles.
- period_valid  out  1  one-cycle pulse when period updates.
- avg_period  out  WIDTH  mean of the last 4 accepted periods.
- avg_valid  out  1  high once 4 periods have been accepted since entering MEASURE.
- rejected  out  1  one-cycle pulse when an edge is dropped by the refractory window.
- timeout  out  1  one-cycle pulse when MAX_PERIOD elapses with no edge.
- active  out  1  high while in state MEASURE.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, history 0, sum 0, synchroniser and edge-history flops 0. Reset has priority over every other event, including mid-measurement.
- Input path: 2-flop synchroniser (s1, s2), then edge register s_old. edge = s2 & !s_old. Latency from clk_in rising to edge is 2-3 cycles and is identical for every edge, so it cancels in the period.
- State IDLE:
  - Counter held at 0.
  - On edge: go to MEASURE, set counter to 1, clear history, sum, count4 and avg_valid. No period_valid.
- State MEASURE, evaluated in this priority order each cycle:
  1. edge and counter >= MIN_PERIOD (accept):
     - period <= counter; period_valid = 1; counter <= 1.
     - Push period into the 4-deep history: sum <= sum + counter - oldest.
     - count4 saturates at 4. avg_valid = 1 once count4 reaches 4.
     - Edges at cycles t0 and t1 therefore give period = t1 - t0.
  2. edge and counter < MIN_PERIOD: rejected = 1. Counter keeps incrementing; the edge has no other effect.
  3. no edge and counter == MAX_PERIOD: timeout = 1; go to IDLE; avg_valid <= 0. period and avg_period hold their last values.
  4. otherwise: counter <= counter + 1.
- Boundaries:
  - An edge on the same cycle counter == MAX_PERIOD is accepted (period = MAX_PERIOD); no timeout.
  - An edge exactly at counter == MIN_PERIOD is accepted.
  - Counter never wraps, because the timeout fires first.
- Arithmetic:
  - sum is WIDTH+2 bits and unsigned.
  - avg_period = sum[WIDTH+1:2], i.e. truncating divide by 4, registered.
  - avg_period updates on the cycle after period_valid.
  - Before 4 samples, avg_period reflects the zero-filled history. Consumers gate on avg_valid.
- active = (state == MEASURE), registered.
- clk_in held high: only one edge is produced, so no retrigger.
- Pulses shorter than one qzt_clk period may be missed. Accepted input pulse width is at least 2 qzt_clk cycles.

Test Plan (bench parameters: MIN_PERIOD=4, MAX_PERIOD=100, WIDTH=30):
- Reset, then clk_in edges every 20 cycles, 6 edges:
  - first edge causes active to rise, with no period_valid;
  - edges 2-6 each produce period_valid with period=20;
  - avg_valid rises after edge 5, with avg_period=20.
- Edges spaced 20, 24, 28, 32 cycles, after the first edge:
  - period reads 20, 24, 28, 32;
  - after the 4th period, avg_period=26 and avg_valid=1.
- Edge 2 cycles after an accepted edge, next edge 18 cycles after that:
  - rejected pulses once;
  - next period=20, which proves the counter was not reset.
- One edge, then silence:
  - timeout pulses when counter reaches 100; active=0; avg_valid=0; period unchanged;
  - next edge only re-arms (no period_valid);
  - the following edge 30 cycles later gives period=30.
- Edges exactly 100 apart: period=100, no timeout. Edges exactly 4 apart: period=4, no rejected.
- Assert reset 10 cycles into a 20-cycle interval: all outputs 0, state IDLE. The next two edges 15 apart give period=15.
